alu_issue_ctrl: RTL and testbench

Initiator side of the packed 4-bit-lane add/sub execution-unit handshake. It accepts a command (two 8-bit packed operands plus an opcode) over valid/ready and validates the opcode. It then drives the execution unit, waits for is_done or a timeout, and returns the result over valid/ready. It sits between the Mini-core decode stage and the packed ALU.

---
 rtl/mini_core_alu_pkg.sv | 21 ++
 rtl/issue_timer.sv | 28 ++
 rtl/alu_issue_ctrl.sv | 139 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mini_core_alu_pkg.sv
// Shared opcode, state and helper definitions for the Mini-core packed add/sub path.
// Imported by the issue controller and reusable by sibling execution-unit issuers.
package mini_core_alu_pkg;

   localparam int OP_W = 2;

   localparam logic [OP_W-1:0] OP_ADD = 2'd0;
   localparam logic [OP_W-1:0] OP_SUB = 2'd1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/issue_timer.sv
// Cycle counter for bounding an execution-unit wait; expired is high when the
// count has reached LIMIT-1, i.e. on the last allowed waiting cycle.
module issue_timer #(
   parameter int LIMIT = 15,
   parameter int TW    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TW-1:0] LAST_COUNT = TW'(LIMIT - 1);

   logic [TW-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign expired = (count_reg == LAST_COUNT);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Initiator for the packed 4-bit-lane add/sub unit: accepts a command, validates
// the opcode, pulses the unit, waits for done or timeout and returns the result.
module alu_issue_ctrl
   import mini_core_alu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int TW             = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [7:0]      cmd_in1,
   input  logic [7:0]      cmd_in2,
   input  logic [OP_W-1:0] cmd_op,
   output logic [7:0]      unit_in1,
   output logic [7:0]      unit_in2,
   output logic [OP_W-1:0] unit_op,
   output logic            unit_start,
   input  logic            unit_is_done,
   input  logic [7:0]      unit_out,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [7:0]      res_data,
   output logic            res_err
);

   state_t state_reg;
   state_t state_next;

   logic accept;
   logic load_result;
   logic load_error;
   logic timer_expired;

   logic [7:0]      unit_in1_reg;
   logic [7:0]      unit_in2_reg;
   logic [OP_W-1:0] unit_op_reg;
   logic [7:0]      res_data_reg;
   logic            res_err_reg;

   // The timer only runs in WAIT and restarts from zero on every entry.
   issue_timer #(
      .LIMIT (TIMEOUT_CYCLES),
      .TW    (TW)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (state_reg != WAIT),
      .enable  (state_reg == WAIT),
      .expired (timer_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      accept      = 1'b0;
      load_result = 1'b0;
      load_error  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               accept = 1'b1;
               if (is_legal_op(cmd_op)) begin
                  state_next = ISSUE;
               end else begin
                  load_error = 1'b1;
                  state_next = RESP;
               end
            end
         end
         ISSUE: begin
            if (unit_is_done) begin
               load_result = 1'b1;
               state_next  = RESP;
            end else begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            // Completion takes priority over a coincident timeout.
            if (unit_is_done) begin
               load_result = 1'b1;
               state_next  = RESP;
            end else if (timer_expired) begin
               load_error = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            if (res_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operands stay held after the operation so the combinational unit stays quiet.
   always_ff @(posedge clk) begin
      if (rst) begin
         unit_in1_reg <= '0;
         unit_in2_reg <= '0;
         unit_op_reg  <= '0;
         res_data_reg <= '0;
         res_err_reg  <= 1'b0;
      end else begin
         if (accept) begin
            unit_in1_reg <= cmd_in1;
            unit_in2_reg <= cmd_in2;
            unit_op_reg  <= cmd_op;
         end
         if (load_result) begin
            res_data_reg <= unit_out;
            res_err_reg  <= 1'b0;
         end else if (load_error) begin
            res_data_reg <= '0;
            res_err_reg  <= 1'b1;
         end
      end
   end

   assign cmd_ready  = (state_reg == IDLE) && !rst;
   assign unit_start = (state_reg == ISSUE);
   assign res_valid  = (state_reg == RESP);
   assign unit_in1   = unit_in1_reg;
   assign unit_in2   = unit_in2_reg;
   assign unit_op    = unit_op_reg;
   assign res_data   = res_data_reg;
   assign res_err    = res_err_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: the execution unit is played by hand-driven
// unit_is_done/unit_out, and every check is an immediate assertion.
module tb_alu_issue_ctrl;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_in1;
   logic [7:0] cmd_in2;
   logic [1:0] cmd_op;
   logic [7:0] unit_in1;
   logic [7:0] unit_in2;
   logic [1:0] unit_op;
   logic       unit_start;
   logic       unit_is_done;
   logic [7:0] unit_out;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic       res_err;

   int vectors     = 0;
   int miscompares = 0;
   int start_cycles = 0;
   int start_base  = 0;

   alu_issue_ctrl #(
      .TIMEOUT_CYCLES (15),
      .TW             (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_in1      (cmd_in1),
      .cmd_in2      (cmd_in2),
      .cmd_op       (cmd_op),
      .unit_in1     (unit_in1),
      .unit_in2     (unit_in2),
      .unit_op      (unit_op),
      .unit_start   (unit_start),
      .unit_is_done (unit_is_done),
      .unit_out     (unit_out),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_data     (res_data),
      .res_err      (res_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (unit_start === 1'b1) start_cycles <= start_cycles + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_in1 = 8'h00; cmd_in2 = 8'h00; cmd_op = 2'd0;
      unit_is_done = 1'b0; unit_out = 8'h00; res_ready = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_unit_start", unit_start, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_err", res_err, 0);
      chk("rst_unit_in1", unit_in1, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_cmd_ready", cmd_ready, 1);

      // ADD 0x35+0x12, done two cycles after start
      start_base = start_cycles;
      cmd_valid = 1'b1; cmd_in1 = 8'h35; cmd_in2 = 8'h12; cmd_op = 2'd0;
      tick();
      cmd_valid = 1'b0;
      chk("add_issue_start", unit_start, 1);
      chk("add_unit_in1", unit_in1, 8'h35);
      chk("add_unit_in2", unit_in2, 8'h12);
      chk("add_unit_op", unit_op, 0);
      chk("add_issue_cmd_ready", cmd_ready, 0);
      tick();
      chk("add_wait_start", unit_start, 0);
      tick();
      unit_is_done = 1'b1; unit_out = 8'h47;
      tick();
      unit_is_done = 1'b0; unit_out = 8'hAA;
      chk("add_res_valid", res_valid, 1);
      chk("add_res_data", res_data, 8'h47);
      chk("add_res_err", res_err, 0);
      chk("add_start_count", start_cycles - start_base, 1);
      handshake();
      chk("add_post_res_valid", res_valid, 0);
      chk("add_post_cmd_ready", cmd_ready, 1);

      // SUB 0x35-0x17, done during ISSUE
      cmd_valid = 1'b1; cmd_in1 = 8'h35; cmd_in2 = 8'h17; cmd_op = 2'd1;
      tick();
      cmd_valid = 1'b0;
      unit_is_done = 1'b1; unit_out = 8'h2E;
      chk("sub_acc1_res_valid", res_valid, 0);
      tick();
      unit_is_done = 1'b0; unit_out = 8'h00;
      chk("sub_acc2_res_valid", res_valid, 1);
      chk("sub_res_data", res_data, 8'h2E);
      chk("sub_res_err", res_err, 0);
      handshake();

      // Illegal opcode
      start_base = start_cycles;
      cmd_valid = 1'b1; cmd_in1 = 8'hFF; cmd_in2 = 8'h01; cmd_op = 2'd2;
      tick();
      cmd_valid = 1'b0;
      chk("ill_unit_start", unit_start, 0);
      chk("ill_res_valid", res_valid, 1);
      chk("ill_res_err", res_err, 1);
      chk("ill_res_data", res_data, 8'h00);
      handshake();
      chk("ill_start_count", start_cycles - start_base, 0);

      // Timeout: unit never completes
      unit_out = 8'h55;
      cmd_valid = 1'b1; cmd_in1 = 8'h11; cmd_in2 = 8'h22; cmd_op = 2'd0;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 14; i++) tick();
      chk("to_last_wait_res_valid", res_valid, 0);
      tick();
      chk("to_res_valid", res_valid, 1);
      chk("to_res_err", res_err, 1);
      chk("to_res_data", res_data, 8'h00);
      handshake();

      // Done on the final WAIT cycle wins over timeout
      cmd_valid = 1'b1; cmd_in1 = 8'h11; cmd_in2 = 8'h22; cmd_op = 2'd0;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 14; i++) tick();
      unit_is_done = 1'b1; unit_out = 8'h66;
      tick();
      unit_is_done = 1'b0; unit_out = 8'h00;
      chk("tod_res_valid", res_valid, 1);
      chk("tod_res_err", res_err, 0);
      chk("tod_res_data", res_data, 8'h66);
      handshake();

      // Backpressure with a second command held valid
      cmd_valid = 1'b1; cmd_in1 = 8'h01; cmd_in2 = 8'h02; cmd_op = 2'd0;
      tick();
      cmd_in1 = 8'h44; cmd_in2 = 8'h11; cmd_op = 2'd1;
      unit_is_done = 1'b1; unit_out = 8'h03;
      tick();
      unit_is_done = 1'b0; unit_out = 8'h00;
      for (int i = 0; i < 5; i++) begin
         chk("bp_res_valid", res_valid, 1);
         chk("bp_res_data", res_data, 8'h03);
         chk("bp_res_err", res_err, 0);
         chk("bp_cmd_ready", cmd_ready, 0);
         tick();
      end
      res_ready = 1'b1;
      #1;
      chk("bp_hs_cmd_ready", cmd_ready, 0);
      tick();
      res_ready = 1'b0;
      chk("bp_idle_cmd_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      chk("bp2_unit_start", unit_start, 1);
      chk("bp2_unit_in1", unit_in1, 8'h44);
      chk("bp2_unit_op", unit_op, 1);
      unit_is_done = 1'b1; unit_out = 8'h33;
      tick();
      unit_is_done = 1'b0;
      chk("bp2_res_data", res_data, 8'h33);
      handshake();

      // Reset in WAIT, then a late done
      cmd_valid = 1'b1; cmd_in1 = 8'h77; cmd_in2 = 8'h88; cmd_op = 2'd0;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("mrst_res_valid", res_valid, 0);
      chk("mrst_unit_start", unit_start, 0);
      chk("mrst_unit_in1", unit_in1, 0);
      chk("mrst_unit_in2", unit_in2, 0);
      chk("mrst_cmd_ready", cmd_ready, 0);
      chk("mrst_res_data", res_data, 0);
      chk("mrst_res_err", res_err, 0);
      rst = 1'b0;
      unit_is_done = 1'b1; unit_out = 8'h99;
      tick();
      unit_is_done = 1'b0;
      chk("late_done_res_valid", res_valid, 0);
      chk("late_done_cmd_ready", cmd_ready, 1);
      tick();
      chk("late_done2_res_valid", res_valid, 0);
      chk("late_done_res_data", res_data, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
